// File: rtl/counter_sequencer.sv
// Control FSM for the 16-bit up/down counter datapath: sequences clear, count-up,
// count-down and bounce runs, with pause/resume and abort.
module counter_sequencer #(
   parameter int NB_W = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      mode,
   input  logic [NB_W-1:0] n_bounces,
   input  logic            pause,
   input  logic            abort,
   input  logic            z,
   input  logic            m,
   output logic            op,
   output logic            c_ld,
   output logic            c_clr,
   output logic            busy,
   output logic            done,
   output logic [NB_W-1:0] bounce_cnt
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_UP    = 3'd2;
   localparam logic [2:0] S_DOWN  = 3'd3;
   localparam logic [2:0] S_PAUSE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [1:0] M_UP     = 2'b00;
   localparam logic [1:0] M_DOWN   = 2'b01;
   localparam logic [1:0] M_BOUNCE = 2'b10;

   localparam logic [NB_W-1:0] CNT_ONE = NB_W'(1'b1);
   localparam logic [NB_W-1:0] CNT_MAX = {NB_W{1'b1}};

   logic [2:0]      state_r, state_nxt_s;
   logic            dir_r, dir_nxt_s;
   logic [1:0]      mode_r, mode_nxt_s;
   logic [NB_W-1:0] n_lat_r, n_lat_nxt_s;
   logic [NB_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;

   // Saturating increment of the completed-bounce counter
   always_comb begin
      if (cnt_r == CNT_MAX) begin
         cnt_inc_s = cnt_r;
      end else begin
         cnt_inc_s = cnt_r + CNT_ONE;
      end
   end

   // Next-state and Mealy control decode; abort beats pause beats normal flow
   always_comb begin
      state_nxt_s = state_r;
      dir_nxt_s   = dir_r;
      mode_nxt_s  = mode_r;
      n_lat_nxt_s = n_lat_r;
      cnt_nxt_s   = cnt_r;
      op          = 1'b0;
      c_ld        = 1'b0;
      c_clr       = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (start && !abort) begin
               cnt_nxt_s = {NB_W{1'b0}};
               if (mode == M_DOWN) begin
                  mode_nxt_s  = M_DOWN;
                  state_nxt_s = S_DOWN;
               end else begin
                  mode_nxt_s  = (mode == M_BOUNCE) ? M_BOUNCE : M_UP;
                  n_lat_nxt_s = (n_bounces == {NB_W{1'b0}}) ? CNT_ONE : n_bounces;
                  state_nxt_s = S_CLEAR;
               end
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_CLEAR: begin
            if (abort) begin
               state_nxt_s = S_IDLE;
            end else begin
               c_clr       = 1'b1;
               state_nxt_s = S_UP;
            end
         end
         S_UP: begin
            op = 1'b0;
            if (abort) begin
               state_nxt_s = S_IDLE;
            end else if (pause) begin
               dir_nxt_s   = 1'b0;
               state_nxt_s = S_PAUSE;
            end else begin
               c_ld = !m;
               if (m) begin
                  state_nxt_s = (mode_r == M_BOUNCE) ? S_DOWN : S_DONE;
               end else begin
                  state_nxt_s = S_UP;
               end
            end
         end
         S_DOWN: begin
            op = 1'b1;
            if (abort) begin
               state_nxt_s = S_IDLE;
            end else if (pause) begin
               dir_nxt_s   = 1'b1;
               state_nxt_s = S_PAUSE;
            end else begin
               c_ld = !z;
               if (z && (mode_r == M_BOUNCE)) begin
                  cnt_nxt_s   = cnt_inc_s;
                  state_nxt_s = (cnt_inc_s == n_lat_r) ? S_DONE : S_UP;
               end else if (z) begin
                  state_nxt_s = S_DONE;
               end else begin
                  state_nxt_s = S_DOWN;
               end
            end
         end
         S_PAUSE: begin
            op = dir_r;
            if (abort) begin
               state_nxt_s = S_IDLE;
            end else if (pause) begin
               state_nxt_s = S_PAUSE;
            end else begin
               state_nxt_s = dir_r ? S_DOWN : S_UP;
            end
         end
         S_DONE: begin
            state_nxt_s = S_IDLE;
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // State, saved direction, latched command and bounce counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= S_IDLE;
         dir_r   <= 1'b0;
         mode_r  <= M_UP;
         n_lat_r <= CNT_ONE;
         cnt_r   <= {NB_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         dir_r   <= dir_nxt_s;
         mode_r  <= mode_nxt_s;
         n_lat_r <= n_lat_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   assign busy       = (state_r != S_IDLE);
   assign done       = (state_r == S_DONE);
   assign bounce_cnt = cnt_r;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer driving a behavioural 16-bit counter
// datapath; expected counter traces are queued at stimulus time and popped on output.
module tb_counter_sequencer;
   localparam int NB_W = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            start, pause, abort;
   logic [1:0]      mode;
   logic [NB_W-1:0] n_bounces;
   logic            z, m, op, c_ld, c_clr, busy, done;
   logic [NB_W-1:0] bounce_cnt;

   logic [15:0] c_r, lim, pre_val;
   logic        pre_en;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0]     exp_q[$], obs_q[$];
   logic [NB_W-1:0] bexp_q[$], bobs_q[$];

   always #5 clk = ~clk;

   counter_sequencer #(.NB_W(NB_W)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .n_bounces(n_bounces),
      .pause(pause), .abort(abort), .z(z), .m(m), .op(op), .c_ld(c_ld),
      .c_clr(c_clr), .busy(busy), .done(done), .bounce_cnt(bounce_cnt)
   );

   // Datapath stand-in: register C with +/-1 adder, clear, and a bench preload port
   always @(posedge clk) begin
      if (pre_en) c_r <= pre_val;
      else if (c_clr) c_r <= 16'd0;
      else if (c_ld) c_r <= op ? c_r - 16'd1 : c_r + 16'd1;
   end
   assign z = (c_r == 16'd0);
   assign m = (c_r == lim);

   task automatic preload(input logic [15:0] v);
      @(negedge clk); pre_en = 1'b1; pre_val = v;
      @(posedge clk); #1; pre_en = 1'b0;
   endtask

   task automatic issue_start(input logic [1:0] md, input logic [NB_W-1:0] nb);
      @(negedge clk); start = 1'b1; mode = md; n_bounces = nb;
      @(posedge clk); #1; start = 1'b0;
   endtask

   // Watches one sequence; cycle index c is the cycle after start edge k+c
   task automatic run_seq(input int budget, input int p_from, input int p_len, input int a_at,
                          output int done_at, output int idle_at, output int dones,
                          output int clrs, output int ld_up, output int ld_dn, output int pw_lds);
      logic [15:0]     last_c;
      logic [NB_W-1:0] last_b;
      obs_q.delete(); bobs_q.delete();
      done_at = -1; idle_at = -1; dones = 0; clrs = 0; ld_up = 0; ld_dn = 0; pw_lds = 0;
      last_c = c_r; last_b = bounce_cnt;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         pause = (c >= p_from) && (c < p_from + p_len);
         abort = (c == a_at);
         #1;
         if (c_r !== last_c) begin obs_q.push_back(c_r); last_c = c_r; end
         if (bounce_cnt !== last_b) begin bobs_q.push_back(bounce_cnt); last_b = bounce_cnt; end
         if (c_clr) clrs++;
         if (c_ld && !op) ld_up++;
         if (c_ld && op) ld_dn++;
         if (c_ld && pause) pw_lds++;
         if (done) begin dones++; if (done_at < 0) done_at = c; end
         if (!busy) begin idle_at = c; break; end
      end
      pause = 1'b0; abort = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; mode = 2'b00;
      n_bounces = '0; pre_en = 1'b0; pre_val = 16'd0; lim = 16'd5;
      #1;
      n_cmp++;
      if ({op, c_ld, c_clr, busy, done, bounce_cnt} !== '0) begin
         n_bad++; $display("FAIL reset_outputs: got %b expected all zero", {op, c_ld, c_clr, busy, done, bounce_cnt});
      end
      preload(16'd0);
      @(negedge clk); reset = 1'b1;
      #1; n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
   endtask

   task automatic test_mode_up(input logic [1:0] md, input logic [15:0] l);
      int d_at, i_at, dn, clrs, lu, ld, pw;
      logic [15:0] e, o;
      lim = l; preload(16'd9);
      exp_q.delete();
      for (int i = 0; i <= int'(l); i++) exp_q.push_back(16'(i));
      issue_start(md, 4'd0);
      run_seq(60, -1, 0, -1, d_at, i_at, dn, clrs, lu, ld, pw);
      n_cmp++; if (d_at !== int'(l) + 2) begin n_bad++; $display("FAIL up_done_cycle: got %0d expected %0d", d_at, int'(l) + 2); end
      n_cmp++; if (dn !== 1 || i_at !== d_at + 1) begin n_bad++; $display("FAIL up_done_pulse: got %0d pulses idle at %0d expected 1 pulse idle at %0d", dn, i_at, d_at + 1); end
      n_cmp++; if (clrs !== 1) begin n_bad++; $display("FAIL up_clr_cycles: got %0d expected 1", clrs); end
      n_cmp++; if (lu !== int'(l) || ld !== 0) begin n_bad++; $display("FAIL up_loads: got up %0d down %0d expected up %0d down 0", lu, ld, l); end
      n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL up_trace_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL up_trace: got %0d expected %0d", o, e); end
      end
   endtask

   task automatic test_mode_down;
      int d_at, i_at, dn, clrs, lu, ld, pw;
      logic [15:0] e, o;
      lim = 16'hFFFF; preload(16'd3);
      exp_q.delete(); exp_q.push_back(16'd2); exp_q.push_back(16'd1); exp_q.push_back(16'd0);
      issue_start(2'b01, 4'd0);
      run_seq(40, -1, 0, -1, d_at, i_at, dn, clrs, lu, ld, pw);
      n_cmp++; if (d_at !== 4 || dn !== 1) begin n_bad++; $display("FAIL down_done: got cycle %0d pulses %0d expected cycle 4 pulses 1", d_at, dn); end
      n_cmp++; if (clrs !== 0) begin n_bad++; $display("FAIL down_no_clr: got %0d expected 0", clrs); end
      n_cmp++; if (ld !== 3 || lu !== 0) begin n_bad++; $display("FAIL down_loads: got down %0d up %0d expected down 3 up 0", ld, lu); end
      n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL down_trace_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL down_trace: got %0d expected %0d", o, e); end
      end
      n_cmp++; if (c_r !== 16'd0) begin n_bad++; $display("FAIL down_final_c: got %0d expected 0", c_r); end
   endtask

   task automatic test_bounce(input logic [NB_W-1:0] nb);
      int d_at, i_at, dn, clrs, lu, ld, pw, nexp;
      logic [15:0] e, o;
      logic [NB_W-1:0] be, bo;
      nexp = (nb == 0) ? 1 : int'(nb);
      lim = 16'd2; preload(16'd5);
      exp_q.delete(); bexp_q.delete();
      exp_q.push_back(16'd0);
      for (int b = 1; b <= nexp; b++) begin
         exp_q.push_back(16'd1); exp_q.push_back(16'd2); exp_q.push_back(16'd1); exp_q.push_back(16'd0);
         bexp_q.push_back(NB_W'(b));
      end
      issue_start(2'b10, nb);
      run_seq(80, -1, 0, -1, d_at, i_at, dn, clrs, lu, ld, pw);
      n_cmp++; if (d_at !== 6 * nexp + 1 || dn !== 1) begin n_bad++; $display("FAIL bounce_done: got cycle %0d pulses %0d expected cycle %0d pulses 1", d_at, dn, 6 * nexp + 1); end
      n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bounce_trace_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL bounce_trace: got %0d expected %0d", o, e); end
      end
      n_cmp++; if (bobs_q.size() != bexp_q.size()) begin n_bad++; $display("FAIL bounce_cnt_steps: got %0d expected %0d", bobs_q.size(), bexp_q.size()); end
      while (bexp_q.size() > 0 && bobs_q.size() > 0) begin
         be = bexp_q.pop_front(); bo = bobs_q.pop_front(); n_cmp++;
         if (bo !== be) begin n_bad++; $display("FAIL bounce_cnt: got %0d expected %0d", bo, be); end
      end
      @(negedge clk); #1; n_cmp++;
      if (bounce_cnt !== NB_W'(nexp)) begin n_bad++; $display("FAIL bounce_cnt_hold: got %0d expected %0d", bounce_cnt, nexp); end
   endtask

   task automatic test_pause;
      int d_at, i_at, dn, clrs, lu, ld, pw;
      logic [15:0] e, o;
      lim = 16'd5; preload(16'd9);
      exp_q.delete();
      for (int i = 0; i <= 5; i++) exp_q.push_back(16'(i));
      issue_start(2'b00, 4'd0);
      run_seq(60, 3, 4, -1, d_at, i_at, dn, clrs, lu, ld, pw);
      n_cmp++; if (d_at !== 12) begin n_bad++; $display("FAIL pause_done_cycle: got %0d expected 12", d_at); end
      n_cmp++; if (pw !== 0) begin n_bad++; $display("FAIL pause_loads: got %0d expected 0", pw); end
      n_cmp++; if (lu !== 5) begin n_bad++; $display("FAIL pause_total_loads: got %0d expected 5", lu); end
      n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL pause_trace_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL pause_trace: got %0d expected %0d", o, e); end
      end
   endtask

   task automatic test_abort(input int with_pause);
      int d_at, i_at, dn, clrs, lu, ld, pw;
      logic [15:0] e, o;
      lim = 16'hFFFF; preload(16'd10);
      exp_q.delete(); exp_q.push_back(16'd9); exp_q.push_back(16'd8); exp_q.push_back(16'd7);
      issue_start(2'b01, 4'd0);
      run_seq(40, with_pause ? 3 : -1, with_pause ? 1 : 0, 3, d_at, i_at, dn, clrs, lu, ld, pw);
      n_cmp++; if (i_at !== 4) begin n_bad++; $display("FAIL abort_idle_cycle: got %0d expected 4", i_at); end
      n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d expected 0", dn); end
      n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL abort_trace_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL abort_trace: got %0d expected %0d", o, e); end
      end
      @(negedge clk); #1; n_cmp++;
      if (c_r !== 16'd7) begin n_bad++; $display("FAIL abort_c_hold: got %0d expected 7", c_r); end
   endtask

   task automatic test_start_abort_idle;
      @(negedge clk); start = 1'b1; abort = 1'b1; mode = 2'b00;
      @(posedge clk); #1; start = 1'b0; abort = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || c_clr !== 1'b0) begin n_bad++; $display("FAIL start_abort_idle: got busy %b clr %b expected 0 0", busy, c_clr); end
   endtask

   task automatic test_reset_mid;
      int d_at, i_at, dn, clrs, lu, ld, pw;
      logic [15:0] e, o;
      lim = 16'd2; preload(16'd5);
      issue_start(2'b10, 4'd3);
      run_seq(8, -1, 0, -1, d_at, i_at, dn, clrs, lu, ld, pw);
      n_cmp++; if (bounce_cnt !== 4'd1 || busy !== 1'b1) begin n_bad++; $display("FAIL mid_bounce_state: got cnt %0d busy %b expected 1 1", bounce_cnt, busy); end
      #2; reset = 1'b0; #1;
      n_cmp++;
      if ({op, c_ld, c_clr, busy, done, bounce_cnt} !== '0) begin
         n_bad++; $display("FAIL reset_mid_outputs: got %b expected all zero", {op, c_ld, c_clr, busy, done, bounce_cnt});
      end
      @(negedge clk); reset = 1'b1;
      preload(16'd5);
      exp_q.delete(); exp_q.push_back(16'd0); exp_q.push_back(16'd1); exp_q.push_back(16'd2);
      issue_start(2'b00, 4'd0);
      run_seq(40, -1, 0, -1, d_at, i_at, dn, clrs, lu, ld, pw);
      n_cmp++; if (clrs !== 1 || d_at !== 4) begin n_bad++; $display("FAIL reset_restart: got clr %0d done %0d expected clr 1 done 4", clrs, d_at); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hDEAD; n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL reset_restart_trace: got %0d expected %0d", o, e); end
      end
   endtask

   initial begin
      test_reset();
      test_mode_up(2'b00, 16'd5);
      test_mode_up(2'b11, 16'd3);
      test_mode_down();
      test_bounce(4'd2);
      test_bounce(4'd0);
      test_pause();
      test_abort(0);
      test_abort(1);
      test_start_abort_idle();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
